// File: rtl/sampq_unpack_if.sv
// Bundle of the sample-queue stream, unpacked-field stream and 8-bit register bus
// used by sampq_unpack.
//   sample / sample_valid / sample_ready : packed 32-bit entries into the unpacker
//   field / field_valid / field_ready    : unpacked 16-bit fields out of the unpacker
//   wb_*                                 : register bus (write strobes, address, data, ack)
// The slave modport is the unpacker's view; master is the view of whatever drives it.
interface sampq_unpack_if;
    logic [31:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] field;
    logic        field_valid;
    logic        field_ready;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [15:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o;

    modport slave (
        input  sample, sample_valid, field_ready,
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
        output sample_ready, field, field_valid, wb_dat_o, wb_ack_o
    );

    modport master (
        output sample, sample_valid, field_ready,
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  sample_ready, field, field_valid, wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/sampq_unpack.sv
// Sample-queue unpacker: takes 32-bit packed entries and emits their N fields of
// W bits each (most significant field first), zero-extended to 16 bits plus a
// programmable offset. A small register file selects the packing type, offset and
// enable, and exposes a 16-bit count of fully emitted entries.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sampq_unpack_if.slave (sample stream in, field stream out, register bus)
module sampq_unpack (
    input logic           clk,
    input logic           rst_n,
    sampq_unpack_if.slave bus
);

    logic        enable_q, enable_d;
    logic [2:0]  dtype_q, dtype_d;
    logic [15:0] offset_q, offset_d;
    logic [15:0] count_q, count_d;
    logic        full_q, full_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] hold_q, hold_d;

    logic [2:0]  last_k;
    logic [3:0]  width;
    logic [2:0]  rem;
    logic [4:0]  shamt;
    logic [15:0] mask;
    logic        wr;
    logic [2:0]  adr;
    logic        at_last;
    logic        sample_ready;
    logic        sample_fire;
    logic        field_fire;
    logic        disable_req;
    logic        unused_bits;

    // Packing type -> (field count - 1, field width); unknown types fall back to 4x8.
    always_comb begin
        last_k = 3'd3;
        width  = 4'd8;
        case (dtype_q)
            3'd1:    begin last_k = 3'd2; width = 4'd10; end
            3'd2:    begin last_k = 3'd1; width = 4'd13; end
            3'd3:    begin last_k = 3'd5; width = 4'd5;  end
            3'd4:    begin last_k = 3'd4; width = 4'd6;  end
            default: begin last_k = 3'd3; width = 4'd8;  end
        endcase
    end

    // Field k sits (N-1-k) fields above bit 0; widest shift is 5*5=25.
    assign rem   = last_k - k_q;
    assign shamt = 5'({2'b00, rem} * {1'b0, width});
    assign mask  = 16'((17'd1 << width) - 17'd1);

    assign bus.field       = (16'(hold_q >> shamt) & mask) + offset_q;
    assign bus.field_valid = full_q;
    assign bus.wb_ack_o    = 1'b1;

    assign adr          = bus.wb_adr_i[2:0];
    assign wr           = bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i;
    assign at_last      = (k_q == last_k);
    // A new entry may land in the same cycle the last field of the current one leaves.
    assign sample_ready = enable_q & (~full_q | (bus.field_ready & at_last));
    assign sample_fire  = bus.sample_valid & sample_ready;
    assign field_fire   = full_q & bus.field_ready;
    assign disable_req  = wr & (adr == 3'd0) & ~bus.wb_dat_i[0];

    assign bus.sample_ready = sample_ready;

    assign unused_bits = ^{bus.wb_adr_i[15:3], bus.wb_dat_i[7], bus.wb_dat_i[3:1]};

    always_comb begin
        enable_d = enable_q;
        dtype_d  = dtype_q;
        offset_d = offset_q;
        count_d  = count_q;
        full_d   = full_q;
        k_d      = k_q;
        hold_d   = hold_q;

        // Type and offset are frozen while enabled so an entry never changes shape mid-way.
        if (wr) begin
            case (adr)
                3'd0: begin
                    enable_d = bus.wb_dat_i[0];
                    if (!enable_q) dtype_d = bus.wb_dat_i[6:4];
                end
                3'd2: if (!enable_q) offset_d[7:0]  = bus.wb_dat_i;
                3'd3: if (!enable_q) offset_d[15:8] = bus.wb_dat_i;
                default: ;
            endcase
        end

        // Clear beats a coincident increment.
        if (wr && (adr == 3'd4 || adr == 3'd5)) begin
            count_d = 16'd0;
        end else if (field_fire && at_last) begin
            count_d = count_q + 16'd1;
        end

        // Disabling drops any partially emitted entry.
        if (disable_req) begin
            full_d = 1'b0;
            k_d    = 3'd0;
        end else if (sample_fire) begin
            hold_d = bus.sample;
            full_d = 1'b1;
            k_d    = 3'd0;
        end else if (field_fire) begin
            if (at_last) begin
                full_d = 1'b0;
                k_d    = 3'd0;
            end else begin
                k_d = k_q + 3'd1;
            end
        end
    end

    always_comb begin
        bus.wb_dat_o = 8'h00;
        case (adr)
            3'd0:    bus.wb_dat_o = {1'b0, dtype_q, 3'b000, enable_q};
            3'd2:    bus.wb_dat_o = offset_q[7:0];
            3'd3:    bus.wb_dat_o = offset_q[15:8];
            3'd4:    bus.wb_dat_o = count_q[7:0];
            3'd5:    bus.wb_dat_o = count_q[15:8];
            default: bus.wb_dat_o = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
            dtype_q  <= 3'd0;
            offset_q <= 16'd0;
            count_q  <= 16'd0;
            full_q   <= 1'b0;
            k_q      <= 3'd0;
            hold_q   <= 32'd0;
        end else begin
            enable_q <= enable_d;
            dtype_q  <= dtype_d;
            offset_q <= offset_d;
            count_q  <= count_d;
            full_q   <= full_d;
            k_q      <= k_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: tb/tb_sampq_unpack.sv
module tb_sampq_unpack;

    typedef struct packed {
        logic [15:0] f;
        logic        last;
    } exp_t;

    logic clk;
    logic rst_n;
    sampq_unpack_if bus ();

    sampq_unpack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pop    = 0;
    bit rand_rdy = 0;

    // Reference model state: what the register file should hold given the writes issued.
    logic        m_en   = 1'b0;
    logic [2:0]  m_type = 3'd0;
    logic [15:0] m_off  = 16'd0;
    logic [15:0] m_cnt  = 16'd0;

    int ns [5] = '{4, 3, 2, 6, 5};
    int ws [5] = '{8, 10, 13, 5, 6};

    exp_t        sb [$];
    logic [15:0] dir_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Split an entry into its fields from the packing rules.
    function automatic void push_model(input logic [31:0] s);
        int t = (m_type > 3'd4) ? 0 : int'(m_type);
        int n = ns[t];
        int w = ws[t];
        for (int k = 0; k < n; k++) begin
            logic [31:0] v;
            logic [15:0] f;
            v = (s >> ((n - 1 - k) * w)) % (32'd1 << w);
            f = v[15:0] + m_off;
            sb.push_back(exp_t'{f: f, last: (k == n - 1)});
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] adr, input logic [7:0] dat);
        bus.wb_adr_i = {13'd0, adr};
        bus.wb_dat_i = dat;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        case (adr)
            3'd0: begin
                if (!m_en) m_type = dat[6:4];
                m_en = dat[0];
            end
            3'd2: if (!m_en) m_off[7:0]  = dat;
            3'd3: if (!m_en) m_off[15:8] = dat;
            3'd4, 3'd5: m_cnt = 16'd0;
            default: ;
        endcase
        tick();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] adr, input logic [7:0] exp);
        bus.wb_adr_i = {13'd0, adr};
        bus.wb_we_i  = 1'b0;
        #1;
        check(name, {24'd0, bus.wb_dat_o}, {24'd0, exp});
    endtask

    task automatic rd_status(input string name);
        rd_check(name, 3'd0, {1'b0, m_type, 3'b000, m_en});
    endtask

    task automatic rd_count(input string name);
        rd_check({name, "_lo"}, 3'd4, m_cnt[7:0]);
        rd_check({name, "_hi"}, 3'd5, m_cnt[15:8]);
    endtask

    // Offer an entry; its expected fields go to the scoreboard when it is accepted.
    task automatic send(input logic [31:0] s, input bit directed);
        bit acc = 0;
        bus.sample       = s;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.sample_ready) begin
                if (directed) begin
                    for (int j = 0; j < dir_q.size(); j++)
                        sb.push_back(exp_t'{f: dir_q[j], last: (j == dir_q.size() - 1)});
                    dir_q.delete();
                end else begin
                    push_model(s);
                end
                acc = 1;
                break;
            end
        end
        if (!acc) fail_now("sample_accept");
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int i = 0; i < 600; i++) begin
            if (sb.size() == 0 && !bus.field_valid) begin
                done = 1;
                break;
            end
            tick();
        end
        if (!done) fail_now(name);
    endtask

    task automatic wait_pops(input int target);
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            if (n_pop >= target) begin
                done = 1;
                break;
            end
            tick();
        end
        if (!done) fail_now("wait_pops");
    endtask

    // Monitor: every field handshake is compared against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.field_valid && bus.field_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL field_unexpected: got 0x%0h expected no field", bus.field);
                end else begin
                    e = sb.pop_front();
                    check("field", {16'd0, bus.field}, {16'd0, e.f});
                    n_pop++;
                    if (e.last) m_cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.field_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] s;
        logic [15:0] off;

        bus.sample       = 32'd0;
        bus.sample_valid = 1'b0;
        bus.field_ready  = 1'b0;
        bus.wb_stb_i     = 1'b0;
        bus.wb_cyc_i     = 1'b0;
        bus.wb_we_i      = 1'b0;
        bus.wb_adr_i     = 16'd0;
        bus.wb_dat_i     = 8'd0;
        rst_n            = 1'b0;

        #12;
        check("rst_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        check("rst_field_valid", {31'd0, bus.field_valid}, 32'd0);
        check("rst_field", {16'd0, bus.field}, 32'd0);
        check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd1);
        rd_check("rst_status", 3'd0, 8'h00);
        rd_check("rst_off_lo", 3'd2, 8'h00);
        rd_check("rst_cnt_lo", 3'd4, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Type 0, offset 0: one byte per cycle, no bubbles.
        wb_write(3'd0, 8'h01);
        bus.field_ready = 1'b1;
        dir_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        send(32'h11223344, 1);
        base = n_pop;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fv_4x8", {31'd0, bus.field_valid}, 32'd1);
        end
        tick();
        check("nobubble_4x8", n_pop - base, 4);
        check("fv_after_4x8", {31'd0, bus.field_valid}, 32'd0);
        rd_check("cnt_one_lo", 3'd4, 8'h01);
        rd_check("cnt_one_hi", 3'd5, 8'h00);

        // Type 1: top two bits ignored.
        wb_write(3'd0, 8'h00);
        wb_write(3'd0, 8'h11);
        rd_status("status_3x10");
        dir_q = '{16'h03FF, 16'h0001, 16'h02AA};
        send(32'hFFF006AA, 1);
        drain("drain_3x10");

        // Offset wraps modulo 2^16.
        wb_write(3'd0, 8'h00);
        wb_write(3'd2, 8'hF0);
        wb_write(3'd3, 8'hFF);
        wb_write(3'd0, 8'h01);
        wb_write(3'd2, 8'h12);
        rd_check("off_locked_lo", 3'd2, 8'hF0);
        rd_check("off_locked_hi", 3'd3, 8'hFF);
        dir_q = '{16'hFFF5, 16'h0010, 16'hFFF0, 16'hFFF0};
        send(32'h05200000, 1);
        drain("drain_off");

        // Type 2, two entries back to back.
        wb_write(3'd0, 8'h00);
        wb_write(3'd2, 8'h00);
        wb_write(3'd3, 8'h00);
        wb_write(3'd0, 8'h21);
        wb_write(3'd0, 8'h41);
        rd_status("type_locked");
        dir_q = '{16'h0001, 16'h0001};
        send(32'h00002001, 1);
        base = n_pop;
        dir_q = '{16'h1FFF, 16'h1FFF};
        send(32'h03FFFFFF, 1);
        @(negedge clk);
        check("fv_b2b", {31'd0, bus.field_valid}, 32'd1);
        @(negedge clk);
        check("sready_last", {31'd0, bus.sample_ready}, 32'd1);
        tick();
        check("nobubble_b2b", n_pop - base, 4);
        drain("drain_b2b");

        // Back-pressure holds the field mid-entry.
        wb_write(3'd0, 8'h00);
        wb_write(3'd0, 8'h01);
        send(32'hA1B2C3D4, 0);
        tick();
        bus.field_ready  = 1'b0;
        bus.sample       = 32'h01020304;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_field", {16'd0, bus.field}, {16'd0, sb[0].f});
            check("hold_sready", {31'd0, bus.sample_ready}, 32'd0);
        end
        tick();
        bus.sample_valid = 1'b0;
        bus.field_ready  = 1'b1;
        drain("drain_hold");
        rd_count("cnt_hold");

        // Disable after two fields of a 6x5 entry.
        wb_write(3'd0, 8'h00);
        wb_write(3'd0, 8'h31);
        send(32'h2ABCDEF1, 0);
        wait_pops(n_pop + 2);
        bus.field_ready = 1'b0;
        wb_write(3'd0, 8'h30);
        check("dis_fv", {31'd0, bus.field_valid}, 32'd0);
        check("dis_sready", {31'd0, bus.sample_ready}, 32'd0);
        sb.delete();
        wb_write(3'd0, 8'h40);
        rd_status("dis_type");
        rd_count("dis_cnt");
        bus.field_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("dis_no_field", {31'd0, bus.field_valid}, 32'd0);
        end
        tick();

        // Counter clear.
        wb_write(3'd5, 8'h00);
        rd_count("cnt_clr");

        // Randomized rounds against the model.
        for (int r = 0; r < 5; r++) begin
            wb_write(3'd0, 8'h00);
            off = 16'($urandom);
            wb_write(3'd2, off[7:0]);
            wb_write(3'd3, off[15:8]);
            wb_write(3'd0, {1'b0, 3'($urandom_range(0, 7)), 4'b0001});
            rand_rdy = 1;
            for (int e = 0; e < 10; e++) begin
                s = $urandom;
                send(s, 0);
                repeat ($urandom_range(0, 2)) tick();
            end
            wb_write(3'd2, 8'h5A);
            wb_write(3'd0, {1'b0, 3'($urandom_range(0, 7)), 4'b0001});
            rand_rdy = 0;
            tick();
            bus.field_ready = 1'b1;
            drain("drain_rand");
            rd_status("rand_status");
            rd_check("rand_off_lo", 3'd2, m_off[7:0]);
            rd_count("rand_cnt");
        end

        // Reset mid-entry discards the rest.
        wb_write(3'd0, 8'h00);
        wb_write(3'd0, 8'h31);
        send(32'h1357ACE0, 0);
        wait_pops(n_pop + 2);
        rst_n = 1'b0;
        #1;
        check("rstmid_fv", {31'd0, bus.field_valid}, 32'd0);
        check("rstmid_field", {16'd0, bus.field}, 32'd0);
        check("rstmid_sready", {31'd0, bus.sample_ready}, 32'd0);
        sb.delete();
        m_en = 1'b0;
        m_type = 3'd0;
        m_off = 16'd0;
        m_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstmid_no_field", {31'd0, bus.field_valid}, 32'd0);
        end
        tick();
        rd_status("rstmid_status");
        rd_count("rstmid_cnt");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
